// File: rtl/program_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : program_memory_arbiter
// Brief    : Shares the program-ROM read port between the instruction-fetch
//            unit (port F) and the debug/loader path (port D). Round-robin
//            arbitration on contention, registered ROM address, registered
//            per-port read data with one-cycle grant/valid pulses.
// Revision : 1.0 - initial release
// ============================================================================
module program_memory_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // Port F: instruction fetch
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  // Port D: debug / loader readback
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_gnt,
  output logic                  dbg_valid,
  output logic [DATA_WIDTH-1:0] dbg_data,
  // Program ROM (combinational read)
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_instruction,
  // Status
  output logic                  misaligned
);

  // Owner of the read currently in flight (the ROM is being addressed for it)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_F = 2'd1;
  localparam logic [1:0] ST_OWN_D = 2'd2;

  // Encoding of the last arbitration winner
  localparam logic WIN_F = 1'b0;
  localparam logic WIN_D = 1'b1;

  logic [1:0] state;
  logic       last_winner;
  logic       grant_f;
  logic       grant_d;

  // Round-robin decision: a lone requester wins; on a tie the port that
  // did not win last time is served.
  always_comb begin
    grant_f = fetch_req & (~dbg_req | (last_winner == WIN_D));
    grant_d = dbg_req & ~grant_f;
  end

  // Accept a request: latch the ROM address, pulse grant/misaligned and
  // record the new owner. The ROM address holds when nothing is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      last_winner <= WIN_D;
      mem_address <= '0;
      fetch_gnt   <= 1'b0;
      dbg_gnt     <= 1'b0;
      misaligned  <= 1'b0;
    end else if (grant_f) begin
      state       <= ST_OWN_F;
      last_winner <= WIN_F;
      mem_address <= fetch_addr;
      fetch_gnt   <= 1'b1;
      dbg_gnt     <= 1'b0;
      misaligned  <= |fetch_addr[1:0];
    end else if (grant_d) begin
      state       <= ST_OWN_D;
      last_winner <= WIN_D;
      mem_address <= dbg_addr;
      fetch_gnt   <= 1'b0;
      dbg_gnt     <= 1'b1;
      misaligned  <= |dbg_addr[1:0];
    end else begin
      state       <= ST_IDLE;
      fetch_gnt   <= 1'b0;
      dbg_gnt     <= 1'b0;
      misaligned  <= 1'b0;
    end
  end

  // Capture the ROM word for the owner of the read accepted one edge ago;
  // the other port's data register is left untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
      dbg_valid   <= 1'b0;
      dbg_data    <= '0;
    end else begin
      fetch_valid <= (state == ST_OWN_F);
      dbg_valid   <= (state == ST_OWN_D);
      if (state == ST_OWN_F) begin
        fetch_data <= mem_instruction;
      end
      if (state == ST_OWN_D) begin
        dbg_data <= mem_instruction;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_memory_arbiter
// Brief    : Self-checking bench for program_memory_arbiter. A behavioural
//            model (queue of accepted reads + round-robin rule) predicts
//            every output each cycle; directed scenarios then random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_gnt;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        dbg_req = 1'b0;
  logic [31:0] dbg_addr = '0;
  logic        dbg_gnt;
  logic        dbg_valid;
  logic [31:0] dbg_data;
  logic [31:0] mem_address;
  logic [31:0] mem_instruction;
  logic        misaligned;

  logic [31:0] rom [64];

  int checks = 0;
  int errors = 0;

  // Expected outputs produced by the model
  logic        exp_fg, exp_fv, exp_dg, exp_dv, exp_mis;
  logic [31:0] exp_fd, exp_dd, exp_ma;

  // Model state: reads accepted but not yet returned, and tie-break memory
  typedef struct { bit is_dbg; logic [31:0] addr; } read_t;
  read_t pending[$];
  bit    m_last_dbg;

  program_memory_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data),
    .mem_address(mem_address), .mem_instruction(mem_instruction),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // Asynchronous-read ROM: word index is the byte address divided by four
  assign mem_instruction = rom[mem_address[7:2]];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return rom[a[7:2]];
  endfunction

  task automatic model_reset();
    pending.delete();
    m_last_dbg = 1'b1;
    exp_fg = 0; exp_fv = 0; exp_dg = 0; exp_dv = 0; exp_mis = 0;
    exp_fd = '0; exp_dd = '0; exp_ma = '0;
  endtask

  // One clock edge of the reference behaviour, using the inputs that were
  // stable before the edge.
  task automatic model_edge();
    read_t r;
    bit    win_f, win_d;
    if (!reset) begin
      model_reset();
      return;
    end
    exp_fv = 0; exp_dv = 0;
    if (pending.size() > 0) begin
      r = pending.pop_front();
      if (r.is_dbg) begin exp_dv = 1; exp_dd = rom_word(r.addr); end
      else          begin exp_fv = 1; exp_fd = rom_word(r.addr); end
    end
    if (fetch_req && dbg_req) begin
      win_f = m_last_dbg; win_d = !m_last_dbg;
    end else begin
      win_f = fetch_req; win_d = dbg_req;
    end
    exp_fg = win_f; exp_dg = win_d; exp_mis = 0;
    if (win_f || win_d) begin
      r.is_dbg   = win_d;
      r.addr     = win_d ? dbg_addr : fetch_addr;
      exp_ma     = r.addr;
      exp_mis    = (r.addr[1:0] != 2'b00);
      m_last_dbg = win_d;
      pending.push_back(r);
    end
  endtask

  task automatic check_all();
    check_value("fetch_gnt",   {31'd0, fetch_gnt},   {31'd0, exp_fg});
    check_value("fetch_valid", {31'd0, fetch_valid}, {31'd0, exp_fv});
    check_value("fetch_data",  fetch_data,           exp_fd);
    check_value("dbg_gnt",     {31'd0, dbg_gnt},     {31'd0, exp_dg});
    check_value("dbg_valid",   {31'd0, dbg_valid},   {31'd0, exp_dv});
    check_value("dbg_data",    dbg_data,             exp_dd);
    check_value("mem_address", mem_address,          exp_ma);
    check_value("misaligned",  {31'd0, misaligned},  {31'd0, exp_mis});
  endtask

  // Advance one clock, update the model at the edge, compare 1 ns later
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  int f_grants, d_grants;
  bit f_next, d_next;

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[2] = 32'h20080005;
    model_reset();

    // Reset held with both ports requesting
    fetch_req = 1; fetch_addr = 32'h0000_0020;
    dbg_req   = 1; dbg_addr   = 32'h0000_0024;
    #1 check_all();
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    check_value("first_grant_f", {31'd0, fetch_gnt}, 32'd1);
    fetch_req = 0;
    cycle();
    dbg_req = 0;
    cycle();
    cycle();

    // Single fetch of word 2
    fetch_req = 1; fetch_addr = 32'h0000_0008;
    cycle();
    check_value("single_addr", mem_address, 32'h0000_0008);
    fetch_req = 0;
    cycle();
    check_value("single_data", fetch_data, 32'h20080005);
    cycle();

    // Misaligned debug read returns the enclosing word
    dbg_req = 1; dbg_addr = 32'h0000_000E;
    cycle();
    check_value("misaligned_pulse", {31'd0, misaligned}, 32'd1);
    dbg_req = 0;
    cycle();
    check_value("misaligned_data", dbg_data, rom[3]);
    cycle();

    // Simultaneous requests after a D win: F first, then D
    fetch_req = 1; fetch_addr = 32'h0;
    dbg_req   = 1; dbg_addr   = 32'h4;
    cycle();
    fetch_req = 0;
    cycle();
    dbg_req = 0;
    check_value("sim_f_data", fetch_data, rom[0]);
    cycle();
    check_value("sim_d_data", dbg_data, rom[1]);
    cycle();

    // Sustained contention for 8 cycles: strict alternation
    fetch_req = 1; fetch_addr = 32'h10;
    dbg_req   = 1; dbg_addr   = 32'h14;
    f_grants = 0; d_grants = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      f_grants += int'(fetch_gnt);
      d_grants += int'(dbg_gnt);
      check_value("contention_one_gnt", {31'd0, fetch_gnt ^ dbg_gnt}, 32'd1);
    end
    check_value("contention_f_count", f_grants, 32'd4);
    check_value("contention_d_count", d_grants, 32'd4);
    fetch_req = 0; dbg_req = 0;
    cycle();
    cycle();

    // Reset the cycle after a fetch grant: the read is discarded
    fetch_req = 1; fetch_addr = 32'h0000_0030;
    cycle();
    fetch_req = 0;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    cycle();
    check_value("rst_mid_no_valid", {31'd0, fetch_valid}, 32'd0);
    reset = 1'b1;
    cycle();
    fetch_req = 1; fetch_addr = 32'h0000_0034;
    cycle();
    fetch_req = 0;
    cycle();
    check_value("rst_mid_recover", fetch_data, rom[13]);

    // Random traffic: requesters hold until granted, may withdraw or
    // chain back-to-back requests
    for (int i = 0; i < 400; i++) begin
      f_next = fetch_req;
      d_next = dbg_req;
      if (fetch_req && exp_fg) f_next = ($urandom_range(0, 1) == 1);
      else if (fetch_req)      f_next = ($urandom_range(0, 9) != 0);
      else                     f_next = ($urandom_range(0, 9) < 4);
      if (dbg_req && exp_dg)   d_next = ($urandom_range(0, 1) == 1);
      else if (dbg_req)        d_next = ($urandom_range(0, 9) != 0);
      else                     d_next = ($urandom_range(0, 9) < 4);
      if (f_next && !(fetch_req && !exp_fg)) fetch_addr = $urandom_range(0, 255);
      if (d_next && !(dbg_req && !exp_dg))   dbg_addr   = $urandom_range(0, 255);
      fetch_req = f_next;
      dbg_req   = d_next;
      cycle();
    end
    fetch_req = 0; dbg_req = 0;
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_memory_arbiter.md
Name: program_memory_arbiter

Overview:
- Shares the single asynchronous-read port of the program memory ROM between two requesters.
  - Port F: the instruction-fetch unit.
  - Port D: the debug/loader path, which reads code words back for inspection.
- Request/grant handshake per port, round-robin fairness on contention.
- Registered address to the ROM and registered per-port read data.
- Sits between the fetch stage / debug interface and the program memory; nothing else drives the ROM address.

Parameters:
- DATA_WIDTH, 32, width of ROM words and of both read-data outputs.
- ADDR_WIDTH, 32, byte-address width of requests and of mem_address.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- fetch_req  input  1  port F read request; held until fetch_gnt.
- fetch_addr  input  ADDR_WIDTH  port F byte address; stable while fetch_req=1.
- fetch_gnt  output  1  one-cycle pulse: port F request accepted.
- fetch_valid  output  1  one-cycle pulse: fetch_data holds the requested word.
- fetch_data  output  DATA_WIDTH  port F read data.
- dbg_req  input  1  port D read request; same rules as port F.
- dbg_addr  input  ADDR_WIDTH  port D byte address.
- dbg_gnt  output  1  port D accept pulse.
- dbg_valid  output  1  port D data-valid pulse.
- dbg_data  output  DATA_WIDTH  port D read data.
- mem_address  output  ADDR_WIDTH  byte address driven to the ROM Address input.
- mem_instruction  input  DATA_WIDTH  ROM Instruction output (combinational, word = rom[address>>2]).
- misaligned  output  1  one-cycle pulse with the accepting grant when the accepted addr[1:0]!=0.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, mem_address=0, FSM=IDLE, last_winner=D (so F wins the first tie). Any in-flight read is discarded; no valid is issued after reset is released.
- FSM holds the owner of the read in flight: IDLE, OWN_F, OWN_D.
- Arbitration is evaluated at every rising edge, independent of state.
  - Exactly one request high: that port wins.
  - Both high: the port that is not last_winner wins.
  - Neither high: next state IDLE.
- On a win at edge N:
  - mem_address <= winner addr; {port}_gnt <= 1 for cycle N..N+1.
  - misaligned <= (addr[1:0]!=0).
  - last_winner <= winner; state <= OWN_winner.
- At edge N+1, if state is OWN_x:
  - {x}_data <= mem_instruction; {x}_valid <= 1 for one cycle.
- Latency: request sampled at edge N, data and valid visible after edge N+1.
- Throughput: one accepted read per cycle; the capture of read N overlaps the grant of read N+1.
- gnt, valid and misaligned are single-cycle pulses, cleared at the next edge unless re-asserted.
- Requester handshake:
  - Holding req high in the cycle gnt is seen is a new back-to-back request, sampled at the next edge.
  - Dropping req before gnt withdraws the request with no side effects.
- Continuous contention (both requesting every cycle): grants alternate F,D,F,D… No port waits more than one cycle.
- Data hold: {x}_data keeps its last captured value until the next {x}_valid; the other port's data is never disturbed.
- Misaligned address:
  - Still served; the ROM truncates to the word.
  - misaligned pulses with gnt, and the aligned word is returned.
- Address is passed unmodified; word-index conversion is done by the ROM.
- No internal queue: at most one read is in flight, and its owner is always the state register.

Test Plan:
- Reset values: hold reset=0 for 3 cycles with both req=1 -> all gnt/valid/misaligned=0, mem_address=0; release -> first grant goes to F.
- Single fetch: fetch_req=1, fetch_addr=0x00000008, ROM word 2=0x20080005 -> fetch_gnt pulse after edge N, mem_address=0x00000008, then fetch_valid=1 with fetch_data=0x20080005 after edge N+1; dbg outputs unchanged.
- Simultaneous requests: F addr 0x0, D addr 0x4 at the same edge, both held until gnt -> F granted first, D granted the next cycle; valids arrive in order F, D with rom[0], rom[1].
- Sustained contention: both req held high for 8 cycles -> 4 F grants and 4 D grants alternating; every data matches its port's address; no cycle without a grant.
- Misaligned: dbg_addr=0x0000000E -> dbg_gnt and misaligned pulse together; dbg_data=rom[3].
- Reset mid-flight: assert reset the cycle after fetch_gnt -> fetch_valid never rises, fetch_data=0; after release a new request completes normally.
